// File: rtl/fft_div_pkg.sv
// Shared widths, FSM state codes and the quotient saturation helper for the
// sequential signed divider.
package fft_div_pkg;

  localparam int DIVIDEND_W_DEF = 24;
  localparam int DIVISOR_W_DEF  = 10;
  localparam int QUOT_W_DEF     = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Largest positive quotient magnitude; a negative result may reach one more.
  localparam logic [DIVIDEND_W_DEF-1:0] SAT_POS = DIVIDEND_W_DEF'((1 << (QUOT_W_DEF - 1)) - 1);
  localparam logic [DIVIDEND_W_DEF-1:0] SAT_NEG = SAT_POS + 1'b1;

  typedef struct packed {
    logic                  ovf;
    logic [QUOT_W_DEF-1:0] q;
  } sat_t;

  // Magnitude plus result sign -> two's-complement quotient clipped to QUOT_W.
  function automatic sat_t sat_q(input logic [DIVIDEND_W_DEF-1:0] mag, input logic neg);
    sat_t r;
    r.ovf = 1'b0;
    r.q   = '0;
    if (!neg) begin
      if (mag > SAT_POS) begin
        r.ovf = 1'b1;
        r.q   = {1'b0, {(QUOT_W_DEF-1){1'b1}}};
      end else begin
        r.q = mag[QUOT_W_DEF-1:0];
      end
    end else begin
      if (mag > SAT_NEG) begin
        r.ovf = 1'b1;
        r.q   = {1'b1, {(QUOT_W_DEF-1){1'b0}}};
      end else begin
        r.q = -mag[QUOT_W_DEF-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the quotient bit.
module fft_div_step
  import fft_div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff;

  assign shifted = {rem_in, dvd_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low bits alone are exact.
  assign diff    = shifted[DIVISOR_W-1:0] - divisor;
  assign rem_out = q_bit ? diff : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/fft_div_24s_10s_seq.sv
// Sequential signed divider, 24s / 10s -> 16s saturated, ap_* block handshake.
// Define FFT_DIV_REMAINDER_EN to add the signed remainder output rem.
module fft_div_24s_10s_seq
  import fft_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic [QUOT_W-1:0]     dout,
  output logic                  ovf,
  output logic                  dz
`ifdef FFT_DIV_REMAINDER_EN
  ,
  output logic [DIVISOR_W-1:0]  rem
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;
  logic                  q_neg;
  logic                  d_neg;
  logic                  dz_op;
  logic                  done;

  logic [DIVIDEND_W-1:0] din0_mag;
  logic [DIVISOR_W-1:0]  din1_mag;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;
  sat_t                  sat;
  logic [QUOT_W-1:0]     q_fix;
  logic                  ovf_fix;

  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = ap_idle & ap_start;
  assign ap_done  = done;

  // Unsigned magnitudes; the most negative inputs map to exactly 2^(W-1).
  assign din0_mag = din0[DIVIDEND_W-1] ? -din0 : din0;
  assign din1_mag = din1[DIVISOR_W-1]  ? -din1 : din1;

  fft_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (prem),
    .dvd_bit (dvd[DIVIDEND_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign sat = sat_q(DIVIDEND_W_DEF'(dvd), q_neg);

  always_comb begin
    q_fix   = QUOT_W'(sat.q);
    ovf_fix = sat.ovf;
    if (dz_op) begin
      q_fix   = d_neg ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}};
      ovf_fix = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      q_neg <= 1'b0;
      d_neg <= 1'b0;
      dz_op <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            dvd   <= din0_mag;
            dvs   <= din1_mag;
            prem  <= '0;
            cnt   <= '0;
            q_neg <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
            d_neg <= din0[DIVIDEND_W-1];
            dz_op <= (din1 == '0);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          dvd  <= {dvd[DIVIDEND_W-2:0], step_q};
          prem <= step_rem;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          dout  <= q_fix;
          ovf   <= ovf_fix;
          dz    <= dz_op;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_DIV_REMAINDER_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rem <= '0;
    end else if (state == S_FIX) begin
      if (dz_op) begin
        rem <= '0;
      end else begin
        rem <= d_neg ? -prem : prem;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_div_24s_10s_seq.sv
// Directed bench for fft_div_24s_10s_seq: values, flags, fixed latency,
// reset abort and back-to-back operation with ap_start held high.
module tb_fft_div_24s_10s_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [23:0] din0;
  logic [9:0]  din1;
  logic [15:0] dout;
  logic        ovf;
  logic        dz;
`ifdef FFT_DIV_REMAINDER_EN
  logic [9:0]  rem;
`endif

  int checks   = 0;
  int failures = 0;

  fft_div_24s_10s_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .ovf      (ovf),
    .dz       (dz)
`ifdef FFT_DIV_REMAINDER_EN
    ,
    .rem      (rem)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One division: ready at the start cycle, done exactly 26 cycles later,
  // outputs stable meanwhile, and a stray start during CALC must be ignored.
  task automatic run(input int a, input int b, input int exp_q, input int exp_ovf,
                     input int exp_dz, input int exp_rem);
    int n;
    int stable;
    logic [15:0] prev;
    @(negedge ap_clk);
    din0     = 24'(a);
    din1     = 10'(b);
    ap_start = 1'b1;
    #1 check("ready_at_start", int'(ap_ready), 1);
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    n      = 0;
    stable = 1;
    prev   = dout;
    while (n < 40) begin
      @(negedge ap_clk);
      n++;
      if (ap_done) break;
      if (dout !== prev) stable = 0;
      if (n == 5) begin
        ap_start = 1'b1;
        din0     = 24'd123;
        din1     = 10'd7;
        #1 check("ready_in_calc", int'(ap_ready), 0);
      end else if (n == 6) begin
        ap_start = 1'b0;
      end
    end
    check("latency", n, 26);
    check("idle_at_done", int'(ap_idle), 1);
    check("dout_stable", stable, 1);
    check("dout", int'($signed(dout)), exp_q);
    check("ovf", int'(ovf), exp_ovf);
    check("dz", int'(dz), exp_dz);
`ifdef FFT_DIV_REMAINDER_EN
    check("rem", int'($signed(rem)), exp_rem);
`endif
    $display("div %0d / %0d -> dout=%0d ovf=%0d dz=%0d latency=%0d", a, b,
             $signed(dout), ovf, dz, n);
    if (exp_rem == 12345) $display("unreachable rem tag");
  endtask

  int bb_a   [3] = '{1000, -7, 8388607};
  int bb_b   [3] = '{10, 2, 1};
  int bb_q   [3] = '{100, -3, 32767};

  initial begin
    int nready;
    int ndone;
    int dones_seen;
    int unstable;
    int rdy;
    logic [15:0] prev;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_ready", int'(ap_ready), 0);
    check("rst_done", int'(ap_done), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dz", int'(dz), 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    run(1000, 10, 100, 0, 0, 0);
    run(-7, 2, -3, 0, 0, -1);
    run(7, -2, -3, 0, 0, 1);
    run(8388607, 1, 32767, 1, 0, 0);
    run(-8388608, 1, -32768, 1, 0, 0);
    run(-8388608, -512, 16384, 0, 0, 0);
    run(32768, 1, 32767, 1, 0, 0);
    run(-32768, 1, -32768, 0, 0, 0);
    run(5, 0, 32767, 0, 1, 0);
    run(-5, 0, -32768, 0, 1, 0);

    // Abort mid-CALC with reset.
    @(negedge ap_clk);
    din0     = 24'd1000;
    din1     = 10'd10;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    repeat (10) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check("abort_idle", int'(ap_idle), 1);
    check("abort_dout", int'(dout), 0);
    check("abort_dz", int'(dz), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    dones_seen = 0;
    repeat (30) begin
      @(negedge ap_clk);
      if (ap_done) dones_seen++;
    end
    check("abort_no_done", dones_seen, 0);
    $display("abort: idle=%0d dout=%0d done_pulses=%0d", ap_idle, dout, dones_seen);
    run(100, -3, -33, 0, 0, 1);

    // Back-to-back with ap_start held high.
    @(negedge ap_clk);
    din0     = 24'(bb_a[0]);
    din1     = 10'(bb_b[0]);
    ap_start = 1'b1;
    nready   = 0;
    ndone    = 0;
    unstable = 0;
    prev     = dout;
    for (int c = 0; c < 86; c++) begin
      if (c > 0) @(negedge ap_clk);
      #1;
      rdy = 0;
      if (ap_done) begin
        if (ndone < 3) begin
          check("bb_dout", int'($signed(dout)), bb_q[ndone]);
          check("bb_done_cycle", c, 26 * (ndone + 1));
          $display("b2b done %0d at cycle %0d dout=%0d", ndone, c, $signed(dout));
        end
        ndone++;
      end else if (dout !== prev) begin
        unstable++;
      end
      prev = dout;
      if (ap_ready) begin
        nready++;
        rdy = 1;
        if (c != 26 * (nready - 1)) check("bb_ready_cycle", c, 26 * (nready - 1));
      end
      @(posedge ap_clk);
      #1;
      if (rdy == 1) begin
        if (nready < 3) begin
          din0 = 24'(bb_a[nready]);
          din1 = 10'(bb_b[nready]);
        end else begin
          ap_start = 1'b0;
        end
      end
    end
    check("bb_ready_count", nready, 3);
    check("bb_done_count", ndone, 3);
    check("bb_dout_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
